// File: rtl/bpsk_ctrl_pkg.sv
// Shared types and helpers for the BPSK frame sequencer.
package bpsk_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPreamble,
        StSync,
        StPayload,
        StGuard
    } state_e;

    localparam logic [6:0] SYNC_WORD_DEFAULT = 7'b1010110;

    // Preamble alternates 1,0,1,0... starting with 1 on symbol 0.
    function automatic logic preamble_bit(input int unsigned k);
        return (k % 2) == 0;
    endfunction

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned w = 1;
        while ((32'd1 << w) < v) w++;
        return w;
    endfunction

endpackage

// File: rtl/bpsk_sym_timer.sv
// Symbol timer: counts 0..N-1 on CE cycles and flags the last clock of each symbol.
module bpsk_sym_timer import bpsk_ctrl_pkg::*; #(
    parameter int unsigned N = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic CE,
    input  logic run,
    input  logic clear,
    output logic sym_strobe
);

    localparam int unsigned CW = clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [CW-1:0] cnt_q;
    logic          last;

    assign last       = (cnt_q == LAST);
    assign sym_strobe = CE & run & last;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt_q <= '0;
        end else if (CE && run) begin
            cnt_q <= last ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/bpsk_frame_ctrl.sv
// BPSK frame sequencer: preamble, sync word, payload bytes (MSB first), guard.
// Define BPSK_DIFF_EN to differentially encode the sync and payload symbols.
module bpsk_frame_ctrl import bpsk_ctrl_pkg::*; #(
    parameter int unsigned N            = 8,
    parameter int unsigned PREAMBLE_LEN = 16,
    parameter logic [6:0]  SYNC_WORD    = SYNC_WORD_DEFAULT,
    parameter int unsigned GUARD_LEN    = 4,
    parameter int unsigned LEN_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             CE,
    input  logic             start,
    input  logic [LEN_W-1:0] frame_len,
    input  logic [7:0]       data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             tx_enb,
    output logic             sg_mod,
    output logic             sym_strobe,
    output logic             busy,
    output logic             done,
    output logic             underrun
);

    localparam int unsigned IDX_W = clog2(PREAMBLE_LEN + GUARD_LEN + 8);
    localparam logic [IDX_W-1:0] PRE_LAST   = IDX_W'(PREAMBLE_LEN - 1);
    localparam logic [IDX_W-1:0] SYNC_LAST  = IDX_W'(6);
    localparam logic [IDX_W-1:0] BYTE_LAST  = IDX_W'(7);
    localparam logic [IDX_W-1:0] GUARD_LAST = IDX_W'(GUARD_LEN - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [LEN_W-1:0]   bytes_q, bytes_d;
    logic [7:0]         shift_q, shift_d;
    logic [7:0]         hold_q, hold_d;
    logic               hold_full_q, hold_full_d;
    logic               underrun_q, underrun_d;
    logic               done_q, done_d;
    logic               sg_q, sg_d;
    logic               strobe, timer_run, timer_clear;
    logic               accept, avail, boundary, start_ok, raw_bit, sending;
    logic [7:0]         next_byte;

    assign timer_run   = (state_q != StIdle);
    assign timer_clear = (state_q == StIdle);

    bpsk_sym_timer #(.N(N)) u_sym_timer (
        .clk        (clk),
        .reset      (reset),
        .CE         (CE),
        .run        (timer_run),
        .clear      (timer_clear),
        .sym_strobe (strobe)
    );

    assign sending    = (state_q == StPreamble) || (state_q == StSync) || (state_q == StPayload);
    assign data_ready = sending & ~hold_full_q;
    assign accept     = data_valid & data_ready;
    assign avail      = hold_full_q | accept;
    assign next_byte  = hold_full_q ? hold_q : data_in;
    assign start_ok   = (state_q == StIdle) & CE & start & (frame_len != '0);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        bytes_d     = bytes_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        underrun_d  = underrun_q;
        done_d      = 1'b0;
        sg_d        = sg_q;
        boundary    = 1'b0;
        raw_bit     = 1'b0;

        if (accept) begin
            hold_d      = data_in;
            hold_full_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (start_ok) begin
                    state_d    = StPreamble;
                    idx_d      = '0;
                    bytes_d    = frame_len;
                    underrun_d = 1'b0;
                end
            end
            StPreamble: begin
                if (strobe) begin
                    if (idx_q == PRE_LAST) begin
                        state_d = StSync;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StSync: begin
                if (strobe) begin
                    if (idx_q == SYNC_LAST) boundary = 1'b1;
                    else                    idx_d    = idx_q + 1'b1;
                end
            end
            StPayload: begin
                if (strobe) begin
                    if (idx_q != BYTE_LAST) begin
                        idx_d = idx_q + 1'b1;
                    end else if (bytes_q == '0) begin
                        state_d = StGuard;
                        idx_d   = '0;
                    end else begin
                        boundary = 1'b1;
                    end
                end
            end
            StGuard: begin
                if (strobe) begin
                    if (idx_q == GUARD_LAST) begin
                        state_d     = StIdle;
                        idx_d       = '0;
                        done_d      = 1'b1;
                        hold_full_d = 1'b0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // A byte landing on the boundary edge goes straight to the shifter.
        if (boundary) begin
            idx_d = '0;
            if (avail) begin
                state_d     = StPayload;
                shift_d     = next_byte;
                hold_full_d = 1'b0;
                bytes_d     = bytes_q - 1'b1;
            end else begin
                state_d    = StGuard;
                underrun_d = 1'b1;
            end
        end

        case (state_d)
            StPreamble: raw_bit = preamble_bit(32'(idx_d));
            StSync:     raw_bit = SYNC_WORD[3'd6 - idx_d[2:0]];
            StPayload:  raw_bit = shift_d[3'd7 - idx_d[2:0]];
            default:    raw_bit = 1'b0;
        endcase

        if (strobe || start_ok) begin
`ifdef BPSK_DIFF_EN
            if (state_d == StSync || state_d == StPayload) begin
                sg_d = ((state_q == StPreamble) ? 1'b0 : sg_q) ^ raw_bit;
            end else begin
                sg_d = raw_bit;
            end
`else
            sg_d = raw_bit;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            bytes_q     <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            underrun_q  <= 1'b0;
            done_q      <= 1'b0;
            sg_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            bytes_q     <= bytes_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            underrun_q  <= underrun_d;
            done_q      <= done_d;
            sg_q        <= sg_d;
        end
    end

    assign busy       = (state_q != StIdle);
    assign tx_enb     = sending;
    assign sg_mod     = sg_q;
    assign sym_strobe = strobe;
    assign done       = done_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_bpsk_frame_ctrl.sv
// Self-checking bench for bpsk_frame_ctrl against a symbol-list reference model.
module tb_bpsk_frame_ctrl;

    localparam int N     = 8;
    localparam int PLEN  = 16;
    localparam int GLEN  = 4;
    localparam int LEN_W = 8;

    logic clk = 1'b0;
    logic reset, CE, start, data_valid;
    logic [LEN_W-1:0] frame_len;
    logic [7:0] data_in;
    logic data_ready, tx_enb, sg_mod, sym_strobe, busy, done, underrun;

    int tests = 0;
    int fails = 0;

    bit         seq_bit[$];
    bit         seq_tx[$];
    bit         exp_ur;
    logic [7:0] frame_bytes[$];
    logic [7:0] src_q[$];

    always #5 clk = ~clk;

    bpsk_frame_ctrl #(
        .N            (N),
        .PREAMBLE_LEN (PLEN),
        .SYNC_WORD    (7'b1010110),
        .GUARD_LEN    (GLEN),
        .LEN_W        (LEN_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .CE         (CE),
        .start      (start),
        .frame_len  (frame_len),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .tx_enb     (tx_enb),
        .sg_mod     (sg_mod),
        .sym_strobe (sym_strobe),
        .busy       (busy),
        .done       (done),
        .underrun   (underrun)
    );

    // Expected per-symbol bit and tx_enb for a frame of len bytes, nsup supplied.
    task automatic build_model(input int len, input int nsup);
        bit         dbits[$];
        bit         prev;
        logic [6:0] sw = 7'b1010110;
        logic [7:0] b;
        seq_bit.delete();
        seq_tx.delete();
        for (int k = 0; k < PLEN; k++) begin
            seq_bit.push_back(k % 2 == 0);
            seq_tx.push_back(1'b1);
        end
        for (int i = 6; i >= 0; i--) dbits.push_back(sw[i]);
        for (int n = 0; n < len && n < nsup; n++) begin
            b = frame_bytes[n];
            for (int i = 7; i >= 0; i--) dbits.push_back(b[i]);
        end
        prev = 1'b0;
        foreach (dbits[i]) begin
`ifdef BPSK_DIFF_EN
            prev = prev ^ dbits[i];
            seq_bit.push_back(prev);
`else
            seq_bit.push_back(dbits[i]);
`endif
            seq_tx.push_back(1'b1);
        end
        for (int g = 0; g < GLEN; g++) begin
            seq_bit.push_back(1'b0);
            seq_tx.push_back(1'b0);
        end
        exp_ur = (nsup < len);
    endtask

    // Entry and exit: #1 after a rising edge.
    task automatic run_frame(input int len, input int nsup, input bit ce_toggle,
                             input int abort_at, input bit poke_start);
        int   m, total, limit, s;
        bit   hs, exp_st, finished;
        logic [3:0] got, exp;
        build_model(len, nsup);
        src_q.delete();
        for (int i = 0; i < nsup; i++) src_q.push_back(frame_bytes[i]);
        total = seq_bit.size() * N;
        limit = total * 2 + 20;
        frame_len  = LEN_W'(len);
        start      = 1'b1;
        CE         = 1'b1;
        data_valid = 1'b0;
        @(posedge clk); #1;
        start     = 1'b0;
        frame_len = LEN_W'($urandom);
        m = 0;
        finished = 1'b0;
        tests++;
        if (underrun !== 1'b0) begin
            fails++;
            $display("FAIL underrun_clear_on_start: got %b want 0", underrun);
        end
        for (int cyc = 0; cyc < limit && !finished; cyc++) begin
            if (abort_at >= 0 && cyc == abort_at) begin
                reset = 1'b1;
                CE    = 1'b1;
                data_valid = 1'b0;
                @(posedge clk); #1;
                reset = 1'b0;
                tests++;
                if ({data_ready, tx_enb, sg_mod, sym_strobe, busy, done, underrun} !== 7'b0) begin
                    fails++;
                    $display("FAIL reset_mid_frame: rdy/tx/sg/st/busy/done/ur=%b want 0000000",
                             {data_ready, tx_enb, sg_mod, sym_strobe, busy, done, underrun});
                end
                for (int i = 0; i < 2 * N; i++) begin
                    @(posedge clk); #1;
                    tests++;
                    if (done !== 1'b0 || busy !== 1'b0) begin
                        fails++;
                        $display("FAIL no_done_after_reset: done=%b busy=%b want 0 0", done, busy);
                    end
                end
                src_q.delete();
                return;
            end
            if (m >= total) begin
                tests++;
                got = {done, busy, tx_enb, sg_mod};
                if (got !== 4'b1000 || underrun !== exp_ur || data_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL frame_end: done/busy/tx/sg=%b ur=%b rdy=%b want 1000 ur=%b rdy=0",
                             got, underrun, data_ready, exp_ur);
                end
                CE = 1'b1;
                data_valid = 1'b0;
                @(posedge clk); #1;
                tests++;
                if (done !== 1'b0 || busy !== 1'b0) begin
                    fails++;
                    $display("FAIL done_one_cycle: done=%b busy=%b want 0 0", done, busy);
                end
                finished = 1'b1;
            end else begin
                s = m / N;
                got = {sg_mod, tx_enb, busy, done};
                exp = {seq_bit[s], seq_tx[s], 1'b1, 1'b0};
                tests++;
                if (got !== exp) begin
                    fails++;
                    $display("FAIL symbol %0d (ce_cycle %0d): sg/tx/busy/done=%b want %b",
                             s, m, got, exp);
                end
                CE = ce_toggle ? cyc[0] : 1'b1;
                data_valid = (src_q.size() > 0);
                data_in    = (src_q.size() > 0) ? src_q[0] : 8'h00;
                start      = poke_start && (cyc == 40);
                if (start) frame_len = LEN_W'($urandom_range(1, 255));
                #1;
                exp_st = CE && (m % N == N - 1);
                tests++;
                if (sym_strobe !== exp_st) begin
                    fails++;
                    $display("FAIL sym_strobe ce_cycle %0d: got %b want %b", m, sym_strobe, exp_st);
                end
                hs = data_valid && data_ready;
                @(posedge clk); #1;
                start = 1'b0;
                if (hs) void'(src_q.pop_front());
                if (CE) m++;
            end
        end
        if (!finished) begin
            tests++;
            fails++;
            $display("FAIL frame_timeout: done not reached within %0d cycles", limit);
        end
        data_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        CE = 1'b1; start = 1'b0; data_valid = 1'b0; frame_len = '0; data_in = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        tests++;
        if ({data_ready, tx_enb, sg_mod, sym_strobe, busy, done, underrun} !== 7'b0) begin
            fails++;
            $display("FAIL reset_state: rdy/tx/sg/st/busy/done/ur=%b want 0000000",
                     {data_ready, tx_enb, sg_mod, sym_strobe, busy, done, underrun});
        end
    endtask

    task automatic test_basic_frame();
        frame_bytes = '{8'hA5, 8'h3C};
        run_frame(2, 2, 1'b0, -1, 1'b0);
    endtask

    task automatic test_underrun();
        frame_bytes = '{8'($urandom), 8'($urandom)};
        run_frame(3, 2, 1'b0, -1, 1'b0);
    endtask

    task automatic test_ce_toggle();
        frame_bytes = '{8'hA5, 8'h3C};
        run_frame(2, 2, 1'b1, -1, 1'b0);
    endtask

    task automatic test_reset_mid_frame();
        frame_bytes = '{8'($urandom), 8'($urandom)};
        run_frame(2, 2, 1'b0, 150, 1'b0);
        frame_bytes = '{8'($urandom)};
        run_frame(1, 1, 1'b0, -1, 1'b0);
    endtask

    task automatic test_ignored_start();
        start = 1'b1; frame_len = '0; CE = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        tests++;
        if (busy !== 1'b0 || tx_enb !== 1'b0) begin
            fails++;
            $display("FAIL zero_len_start: busy=%b tx=%b want 0 0", busy, tx_enb);
        end
        frame_bytes = '{8'($urandom)};
        run_frame(1, 1, 1'b0, -1, 1'b1);
    endtask

    task automatic test_diff_ff();
        frame_bytes = '{8'hFF};
        run_frame(1, 1, 1'b0, -1, 1'b0);
    endtask

    task automatic test_random_frames();
        int len, nsup;
        for (int f = 0; f < 4; f++) begin
            len = $urandom_range(1, 3);
            nsup = ($urandom_range(0, 2) == 0) ? $urandom_range(0, len - 1) : len;
            frame_bytes.delete();
            for (int i = 0; i < len; i++) frame_bytes.push_back(8'($urandom));
            run_frame(len, nsup, 1'($urandom_range(0, 1)), -1, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_underrun();
        test_ce_toggle();
        test_reset_mid_frame();
        test_ignored_start();
        test_diff_ff();
        test_random_frames();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
